processor_16_bit_risc: RTL and testbench
========================================

# processor_16_bit_risc

Three-stage pipelined accumulator processor with 16-bit data and 12-bit instructions. It holds a 1024 x 12 instruction memory (`memory`) and a 128 x 16 data register bank (`regbank`). Both arrays are internal, and the bench preloads them hierarchically. Stages: fetch (`L12_*`), decode/operand (`L23_*`), execute (`L3_*`). AC, E, PC and the halt state are exported for observation.

## Interface
- No parameters. Sizes are fixed: PC 10 b, data 16 b, instruction 12 b, register bank 128 words.
- clk1  in  1  Single system clock; rising-edge.
- rst_n  in  1  Asynchronous active-low reset.
- pc  out  10  Current fetch PC.
- ac  out  16  Accumulator (`L3_AC`).
- e  out  1  Carry/extend flag (`L3_E`).
- halted  out  1  `HALTED` flag.

## Operation
- Instruction fields:
  - [11] I: indirect.
  - [10:7] op.
  - [6:0] addr.
- Effective address: `ADDR = addr`. If I=1, `ADDR = regbank[addr][6:0]`.
- Memory-reference ops, operand M = `regbank[ADDR]`:
  - 0000 AND: AC&=M.
  - 0001 OR: AC|=M.
  - 0010 XOR: AC^=M.
  - 0011 LDA: AC=M.
  - 0100 STA: M=AC.
  - 0101 ADD: {E,AC}=AC+M.
  - 0110 SUB: {E,AC}=AC+~M+1 (E=1 means no borrow).
  - 1000 ISZ: M=M+1; skip if the result is 0.
- 0111 BUN: PC={3'b0,ADDR}.
- 1001–1110: NOP.
- 1111 register-reference (I ignored); [6:0] is an enumerated micro-op:
  - 0 NOP, 1 CLA, 2 CMA, 3 CLE, 4 CME, 5 INC (AC+1, E unchanged).
  - 6 CIR: AC={E,AC[15:1]}, E=AC[0].
  - 7 CIL: AC={AC[14:0],E}, E=AC[15].
  - 8 SZA, 9 SPA (AC[15]=0), 10 SNA (AC[15]=1), 11 SZE (E=0).
  - 12 HLT.
  - Others: NOP.
- Fetch stage: `L12_IR<=memory[PC]`, PC<=PC+1 (wraps 1023→0), valid bit set.
- Decode stage:
  - Latches `L23_IR` and `ADDR`, and `DR<=regbank[ADDR]`.
  - `L23_Exe_type`: 00 memory-ref, 01 register-ref, 10 branch, 11 NOP/invalid.
- Forwarding: if execute writes `regbank[X]` on the same edge that decode reads X, DR takes the written value.
- Execute stage: updates AC/E, writes regbank (STA, ISZ), and resolves control.
- Skip: a true skip condition sets `SKIPPED`. The next valid instruction reaching execute is annulled (no state change) and clears `SKIPPED`.
- BUN taken: PC<=target; L12 and L23 are invalidated, so the two younger instructions never execute.
- HLT: sets `HALTED`. While halted, PC and all pipeline registers freeze and the instructions behind HLT never execute. Only reset clears `HALTED`.
- An annulled (skipped) BUN/HLT has no effect.

## Timing
- Reset values: PC=0, AC=0, E=0, `SKIPPED`=0, `HALTED`=0, IRs=0, valids=0, `ADDR`=0, `DR`=0, `L23_Exe_type`=11. Memory and regbank contents are not reset.
- Reset asserted mid-operation clears pipeline state immediately. Fetch restarts at address 0 on the first edge after release.
- Latency: an instruction fetched at edge k is in decode at k+1. Its AC/E/regbank effect is visible after edge k+2.
- Throughput: 1 instruction/cycle.
- Taken BUN costs 2 bubbles. A skip consumes the next instruction's execute slot.
- Arithmetic: 16-bit; carry out goes to E. INC wraps 0xFFFF→0.

## Configuration
- `PROC_INDIRECT_EN` defined: I=1 performs the indirect lookup described above.
- `PROC_INDIRECT_EN` undefined: bit 11 is ignored and every address is direct.

## Test plan
- Setup for the program test: `regbank[i]=i+1`, memory[0..5] = 0x280, 0x181, 0x782, 0x788, 0x283, 0x286. Reset, run 8 cycles.
  - After each execute, AC = 1, 2, 0xFFFD, 0xFFFD, 0x0001 (E=1), 0x0008 (E=0).
  - SZA does not skip; `SKIPPED` stays 0.
- BUN: memory[0]=BUN 5, memory[1..2]=LDA, memory[5]=LDA 9 → AC=10. The two instructions after BUN never change AC.
- Forwarding: STA 20 immediately followed by LDA 20, with AC=0x1234 → AC=0x1234 and `regbank[20]`=0x1234.
- ISZ skip: `regbank[7]`=0xFFFF, ISZ 7 then LDA 1 then LDA 2 → `regbank[7]`=0, LDA 1 annulled, AC=3.
- HLT: HLT then LDA 1 → `halted`=1, PC frozen, AC unchanged for 10 cycles. Asserting rst_n low clears `halted` and PC=0.
- Indirect (`PROC_INDIRECT_EN` defined): `regbank[3]`=0x0010, LDA with I=1 and addr 3 → AC=0x0011.

Source files
------------

// File: rtl/processor_16_bit_risc_if.sv
// Observation bundle for processor_16_bit_risc: fetch PC, accumulator, E flag and halt state.
interface processor_16_bit_risc_if;
  logic [9:0]  pc;
  logic [15:0] ac;
  logic        e;
  logic        halted;

  modport master (output pc, ac, e, halted);
  modport slave  (input  pc, ac, e, halted);
endinterface

// File: rtl/processor_16_bit_risc.sv
// Three-stage (fetch/decode/execute) accumulator processor, 12-bit instructions, 16-bit data.
// Define PROC_INDIRECT_EN to make instruction bit 11 select indirect addressing through regbank.
module processor_16_bit_risc (
  input  logic                    clk1,
  input  logic                    rst_n,
  processor_16_bit_risc_if.master bus
);
  typedef enum logic [1:0] {
    EXE_MEM = 2'b00,
    EXE_REG = 2'b01,
    EXE_BRN = 2'b10,
    EXE_NOP = 2'b11
  } exe_type_t;

  // Contents are loaded from outside; the zero initialiser only gives the array a defined start.
  logic [11:0] memory  [1024] = '{default: '0};
  logic [15:0] regbank [128];

  logic [9:0]  pc;
  logic [11:0] l12_ir;
  logic        l12_valid;
  logic [11:0] l23_ir;
  logic        l23_valid;
  logic [6:0]  l23_addr;
  logic [15:0] dr;
  exe_type_t   l23_exe_type;
  logic [15:0] l3_ac;
  logic        l3_e;
  logic        skipped;
  logic        halted;

  logic [3:0]  d_op;
  logic [6:0]  d_addr;
  logic [15:0] d_dr;
  exe_type_t   d_type;

  logic        exec;
  logic [15:0] ac_n;
  logic        e_n;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;
  logic        skip_cond;
  logic        bun_take;
  logic        hlt_take;
  logic        unused_bits;

`ifdef PROC_INDIRECT_EN
  logic [15:0] ptr_word;
  assign unused_bits = ^{l23_ir[11], ptr_word[15:7]};
`else
  assign unused_bits = l23_ir[11];
`endif

  // Decode: resolve the effective address and operand, bypassing a regbank write on the same edge.
  always_comb begin
    d_op   = l12_ir[10:7];
    d_addr = l12_ir[6:0];
`ifdef PROC_INDIRECT_EN
    ptr_word = (wr_en && wr_addr == l12_ir[6:0]) ? wr_data : regbank[l12_ir[6:0]];
    if (l12_ir[11] && d_op != 4'hF)
      d_addr = ptr_word[6:0];
`endif
    d_dr = (wr_en && wr_addr == d_addr) ? wr_data : regbank[d_addr];
    d_type = EXE_NOP;
    if (l12_valid) begin
      case (d_op)
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8: d_type = EXE_MEM;
        4'h7:    d_type = EXE_BRN;
        4'hF:    d_type = EXE_REG;
        default: d_type = EXE_NOP;
      endcase
    end
  end

  always_comb begin
    exec      = l23_valid && !halted && !skipped;
    ac_n      = l3_ac;
    e_n       = l3_e;
    wr_en     = 1'b0;
    wr_addr   = l23_addr;
    wr_data   = l3_ac;
    skip_cond = 1'b0;
    bun_take  = 1'b0;
    hlt_take  = 1'b0;
    if (exec) begin
      case (l23_exe_type)
        EXE_MEM: begin
          case (l23_ir[10:7])
            4'h0: ac_n = l3_ac & dr;
            4'h1: ac_n = l3_ac | dr;
            4'h2: ac_n = l3_ac ^ dr;
            4'h3: ac_n = dr;
            4'h4: wr_en = 1'b1;
            4'h5: {e_n, ac_n} = {1'b0, l3_ac} + {1'b0, dr};
            4'h6: {e_n, ac_n} = {1'b0, l3_ac} + {1'b0, ~dr} + 17'd1;
            4'h8: begin
              wr_en     = 1'b1;
              wr_data   = dr + 16'd1;
              skip_cond = (dr == 16'hFFFF);
            end
            default: ;
          endcase
        end
        EXE_REG: begin
          case (l23_ir[6:0])
            7'd1:  ac_n = 16'h0000;
            7'd2:  ac_n = ~l3_ac;
            7'd3:  e_n  = 1'b0;
            7'd4:  e_n  = ~l3_e;
            7'd5:  ac_n = l3_ac + 16'd1;
            7'd6: begin
              ac_n = {l3_e, l3_ac[15:1]};
              e_n  = l3_ac[0];
            end
            7'd7: begin
              ac_n = {l3_ac[14:0], l3_e};
              e_n  = l3_ac[15];
            end
            7'd8:  skip_cond = (l3_ac == 16'h0000);
            7'd9:  skip_cond = !l3_ac[15];
            7'd10: skip_cond = l3_ac[15];
            7'd11: skip_cond = !l3_e;
            7'd12: hlt_take  = 1'b1;
            default: ;
          endcase
        end
        EXE_BRN: bun_take = 1'b1;
        EXE_NOP: ;
        default: ;
      endcase
    end
  end

  always @(posedge clk1) begin
    if (wr_en)
      regbank[wr_addr] <= wr_data;
  end

  // A taken branch squashes both younger stages; HLT freezes everything from its own edge on.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= '0;
      l12_ir       <= '0;
      l12_valid    <= 1'b0;
      l23_ir       <= '0;
      l23_valid    <= 1'b0;
      l23_addr     <= '0;
      dr           <= '0;
      l23_exe_type <= EXE_NOP;
      l3_ac        <= '0;
      l3_e         <= 1'b0;
      skipped      <= 1'b0;
      halted       <= 1'b0;
    end else if (!halted) begin
      l3_ac <= ac_n;
      l3_e  <= e_n;
      if (hlt_take)
        halted <= 1'b1;
      if (l23_valid && skipped)
        skipped <= 1'b0;
      else if (skip_cond)
        skipped <= 1'b1;
      if (bun_take) begin
        pc           <= {3'b000, l23_addr};
        l12_valid    <= 1'b0;
        l23_valid    <= 1'b0;
        l23_exe_type <= EXE_NOP;
      end else if (!hlt_take) begin
        l12_ir       <= memory[pc];
        l12_valid    <= 1'b1;
        pc           <= pc + 10'd1;
        l23_ir       <= l12_ir;
        l23_valid    <= l12_valid;
        l23_addr     <= d_addr;
        dr           <= d_dr;
        l23_exe_type <= d_type;
      end
    end
  end

  assign bus.pc     = pc;
  assign bus.ac     = l3_ac;
  assign bus.e      = l3_e;
  assign bus.halted = halted;
endmodule

// File: tb/tb_processor_16_bit_risc.sv
// Testbench for processor_16_bit_risc: directed pipeline scenarios plus random programs
// compared against a sequential instruction-set interpreter.
module tb_processor_16_bit_risc;
`ifdef PROC_INDIRECT_EN
  localparam bit INDIRECT = 1'b1;
`else
  localparam bit INDIRECT = 1'b0;
`endif

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [11:0] prog [1024];
  logic [15:0] regs [128];
  logic [15:0] mrb  [128];

  processor_16_bit_risc_if bus ();

  processor_16_bit_risc dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk1 = ~clk1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic defaultImage();
    for (int i = 0; i < 1024; i++) prog[i] = 12'h780;
    for (int i = 0; i < 128; i++) regs[i] = 16'(i + 1);
  endtask

  // Load the images into the design while reset is held, then release on a falling edge.
  task automatic applyStimulus();
    @(negedge clk1);
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) dut.memory[i] = prog[i];
    for (int i = 0; i < 128; i++) dut.regbank[i] = regs[i];
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  // Sequential interpreter: one instruction at a time, skip drops the next instruction.
  task automatic runModel(output logic [15:0] m_ac, output logic m_e, output logic m_halt);
    int          mpc;
    int          t;
    bit          skip;
    logic [11:0] ir;
    logic [6:0]  ea;
    logic [15:0] m;
    logic        old_e;
    for (int i = 0; i < 128; i++) mrb[i] = regs[i];
    mpc = 0; m_ac = 16'h0; m_e = 1'b0; m_halt = 1'b0; skip = 1'b0;
    for (int step = 0; step < 4000 && !m_halt; step++) begin
      ir  = prog[mpc];
      mpc = (mpc + 1) % 1024;
      if (skip) begin
        skip = 1'b0;
        continue;
      end
      ea = ir[6:0];
      if (INDIRECT && ir[11] && ir[10:7] != 4'hF) ea = mrb[ir[6:0]][6:0];
      m = mrb[ea];
      case (ir[10:7])
        4'd0: m_ac = m_ac & m;
        4'd1: m_ac = m_ac | m;
        4'd2: m_ac = m_ac ^ m;
        4'd3: m_ac = m;
        4'd4: mrb[ea] = m_ac;
        4'd5: begin
          t = int'(m_ac) + int'(m);
          m_e = (t > 65535);
          m_ac = t[15:0];
        end
        4'd6: begin
          t = int'(m_ac) - int'(m);
          m_e = (m_ac >= m);
          m_ac = t[15:0];
        end
        4'd7: mpc = int'(ea);
        4'd8: begin
          mrb[ea] = m + 16'd1;
          if (mrb[ea] == 16'h0) skip = 1'b1;
        end
        4'd15: begin
          old_e = m_e;
          case (int'(ir[6:0]))
            1:  m_ac = 16'h0;
            2:  m_ac = ~m_ac;
            3:  m_e = 1'b0;
            4:  m_e = ~m_e;
            5:  m_ac = m_ac + 16'd1;
            6:  begin m_e = m_ac[0];  m_ac = (m_ac >> 1) | (16'(old_e) << 15); end
            7:  begin m_e = m_ac[15]; m_ac = (m_ac << 1) | 16'(old_e); end
            8:  skip = (m_ac == 16'h0);
            9:  skip = (m_ac < 16'h8000);
            10: skip = (m_ac >= 16'h8000);
            11: skip = (m_e == 1'b0);
            12: m_halt = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [11:0] genInstr(input int a);
    int         r;
    int         k;
    logic [3:0] op;
    r = $urandom_range(0, 9);
    if (r < 6) begin
      k  = $urandom_range(0, 7);
      op = (k == 7) ? 4'd8 : 4'(k);
      return {1'($urandom_range(0, 1)), op, 7'($urandom_range(0, 127))};
    end else if (r == 6) begin
      return {1'b0, 4'd7, 7'($urandom_range(a + 1, 32))};
    end else if (r == 7) begin
      return {1'b0, 4'(9 + $urandom_range(0, 5)), 7'($urandom_range(0, 127))};
    end
    return {1'($urandom_range(0, 1)), 4'hF, 7'($urandom_range(0, 15))};
  endfunction

  task automatic waitHalt(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk1);
      if (bus.halted) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin : main
    logic [15:0] acExp [6];
    logic [15:0] m_ac;
    logic        m_e;
    logic        m_halt;
    logic [9:0]  hpc;
    bit          ok;

    // Reset state while rst_n is held low from time zero.
    #12;
    checkOutput("rst_pc", 32'(bus.pc), 32'd0);
    checkOutput("rst_ac", 32'(bus.ac), 32'd0);
    checkOutput("rst_e", 32'(bus.e), 32'd0);
    checkOutput("rst_halted", 32'(bus.halted), 32'd0);

    // Straight-line program: one result per cycle from edge 3 on.
    defaultImage();
    prog[0] = 12'h280; prog[1] = 12'h181; prog[2] = 12'h782;
    prog[3] = 12'h788; prog[4] = 12'h283; prog[5] = 12'h286;
    acExp[0] = 16'h0001; acExp[1] = 16'h0002; acExp[2] = 16'hFFFD;
    acExp[3] = 16'hFFFD; acExp[4] = 16'h0001; acExp[5] = 16'h0008;
    applyStimulus();
    repeat (2) @(negedge clk1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk1);
      checkOutput($sformatf("prog_ac%0d", i), 32'(bus.ac), 32'(acExp[i]));
      if (i == 3) checkOutput("prog_sza_noskip", 32'(dut.skipped), 32'd0);
      if (i == 4) checkOutput("prog_e_carry", 32'(bus.e), 32'd1);
      if (i == 5) checkOutput("prog_e_clear", 32'(bus.e), 32'd0);
    end

    // Taken branch squashes the two following instructions.
    defaultImage();
    prog[0] = 12'h385; prog[1] = 12'h181; prog[2] = 12'h182; prog[5] = 12'h189;
    applyStimulus();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk1);
      checkOutput($sformatf("bun_ac_c%0d", c), 32'(bus.ac), (c >= 6) ? 32'h000A : 32'h0000);
    end

    // Store immediately followed by a load of the same word.
    defaultImage();
    regs[50] = 16'h1234;
    prog[0] = 12'h1B2; prog[1] = 12'h214; prog[2] = 12'h194;
    applyStimulus();
    repeat (5) @(negedge clk1);
    checkOutput("fwd_ac", 32'(bus.ac), 32'h1234);
    checkOutput("fwd_rb20", 32'(dut.regbank[20]), 32'h1234);

    // ISZ wraps to zero and annuls the next instruction.
    defaultImage();
    regs[7] = 16'hFFFF;
    prog[0] = 12'h407; prog[1] = 12'h181; prog[2] = 12'h182;
    applyStimulus();
    repeat (4) @(negedge clk1);
    checkOutput("isz_rb7", 32'(dut.regbank[7]), 32'h0);
    checkOutput("isz_annul_ac", 32'(bus.ac), 32'h0);
    @(negedge clk1);
    checkOutput("isz_ac", 32'(bus.ac), 32'h3);

    // HLT freezes the machine until reset.
    defaultImage();
    prog[0] = 12'h78C; prog[1] = 12'h181;
    applyStimulus();
    repeat (3) @(negedge clk1);
    checkOutput("hlt_halted", 32'(bus.halted), 32'd1);
    hpc = bus.pc;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk1);
      checkOutput($sformatf("hlt_pc_c%0d", c), 32'(bus.pc), 32'(hpc));
      checkOutput($sformatf("hlt_ac_c%0d", c), 32'(bus.ac), 32'h0);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("hlt_rst_halted", 32'(bus.halted), 32'd0);
    checkOutput("hlt_rst_pc", 32'(bus.pc), 32'd0);

`ifdef PROC_INDIRECT_EN
    defaultImage();
    regs[3] = 16'h0010;
    prog[0] = 12'h983;
    applyStimulus();
    repeat (3) @(negedge clk1);
    checkOutput("ind_ac", 32'(bus.ac), 32'h0011);
`endif

    // Random programs: forward-only branches, HLT-filled tail, compared after halt.
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 1024; i++) prog[i] = 12'h78C;
      for (int a = 0; a < 32; a++) prog[a] = genInstr(a);
      for (int i = 0; i < 128; i++) regs[i] = 16'($urandom);
      runModel(m_ac, m_e, m_halt);
      applyStimulus();
      waitHalt(400, ok);
      checkOutput($sformatf("rnd%0d_halted", p), 32'(ok), 32'(m_halt));
      checkOutput($sformatf("rnd%0d_ac", p), 32'(bus.ac), 32'(m_ac));
      checkOutput($sformatf("rnd%0d_e", p), 32'(bus.e), 32'(m_e));
      for (int i = 0; i < 128; i++)
        checkOutput($sformatf("rnd%0d_rb%0d", p, i), 32'(dut.regbank[i]), 32'(mrb[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
